// File: rtl/uart_pkg.sv
// Shared types and constants for the UART requester.
// Build option: define UART_REQ_PARITY_EN for 8E1 framing; otherwise frames are 8N1.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_B0,
        RECV_B0,
        WAIT_B1,
        RECV_B1,
        DONE
    } req_state_e;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned DEFAULT_TIMEOUT_BITS = 40;
    localparam int unsigned DATA_BITS            = 8;

`ifdef UART_REQ_PARITY_EN
    localparam int unsigned FRAME_LEN = 11;
`else
    localparam int unsigned FRAME_LEN = 10;
`endif

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Two-byte reply as delivered to local logic
    typedef struct packed {
        logic [7:0] code;
        logic [7:0] data;
    } uart_rsp_t;

    // Even parity: XOR of the data bits
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Receive path: rx synchroniser, start-bit qualification, mid-bit sampling and
// stop/parity checking for one byte. Starts only while armed by the requester.
// Build option: UART_REQ_PARITY_EN adds an even-parity check before the stop bit.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)
(
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       rx,
    input  logic       enable,
    output logic       fall_c,
    output logic       glitch,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W    = $clog2(FRAME_LEN);
    localparam int unsigned HALF     = CLKS_PER_BIT / 2;
    localparam int unsigned STOP_IDX = FRAME_LEN - 1;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic [BIT_W-1:0] bit_idx;
    logic [7:0]       shift;

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            rx_meta <= UART_IDLE_LEVEL;
            rx_sync <= UART_IDLE_LEVEL;
            rx_prev <= UART_IDLE_LEVEL;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall_c = rx_prev & ~rx_sync;

    // Start bit is checked half a bit in; every later sample is one bit apart
    assign limit = (bit_idx == '0) ? CNT_W'(HALF - 1) : CNT_W'(CLKS_PER_BIT - 1);

    // Bit sampler and frame checker
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            active     <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
            glitch     <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err        <= 1'b0;
            glitch     <= 1'b0;
            if (!active) begin
                if (enable && fall_c) begin
                    active  <= 1'b1;
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            end else if (cnt != limit) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt     <= '0;
                bit_idx <= bit_idx + 1'b1;
                if (bit_idx == '0) begin
                    if (rx_sync) begin
                        active <= 1'b0;
                        glitch <= 1'b1;
                    end
                end else if (bit_idx <= BIT_W'(DATA_BITS)) begin
                    shift <= {rx_sync, shift[7:1]};
`ifdef UART_REQ_PARITY_EN
                end else if (bit_idx != BIT_W'(STOP_IDX)) begin
                    if (rx_sync != even_parity(shift)) begin
                        active <= 1'b0;
                        err    <= 1'b1;
                    end
`endif
                end else begin
                    active <= 1'b0;
                    if (rx_sync) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= shift;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_requester.sv
// Host-side UART initiator: sends one command byte, then collects a two-byte
// reply (code, data) with a per-byte start timeout.
// Build option: define UART_REQ_PARITY_EN for 8E1 frames in both directions.
module uart_requester
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
)
(
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cmd,
    input  logic       rx,
    output logic       tx,
    output logic       rsp_valid,
    output logic [7:0] rsp_code,
    output logic [7:0] rsp_data,
    output logic       timeout,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W      = $clog2(FRAME_LEN);
    localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TMO_W      = $clog2(TMO_CYCLES);
    localparam int unsigned TXS_W      = FRAME_LEN - 1;

    req_state_e       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TXS_W-1:0] tx_frame;
    logic [TXS_W-1:0] tx_load;
    logic [7:0]       code_shadow;
    logic [7:0]       data_shadow;
    uart_rsp_t        rsp_q;

    logic             rx_arm;
    logic             rx_fall_c;
    logic             rx_glitch;
    logic             rx_byte_valid;
    logic [7:0]       rx_byte;
    logic             rx_err;

    // Bits following the start bit, LSB first, stop bit last
`ifdef UART_REQ_PARITY_EN
    assign tx_load = {UART_IDLE_LEVEL, even_parity(req_cmd), req_cmd};
`else
    assign tx_load = {UART_IDLE_LEVEL, req_cmd};
`endif

    assign rx_arm   = (state == WAIT_B0) || (state == WAIT_B1);
    assign rsp_code = rsp_q.code;
    assign rsp_data = rsp_q.data;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clk_50mhz  (clk_50mhz),
        .reset      (reset),
        .rx         (rx),
        .enable     (rx_arm),
        .fall_c     (rx_fall_c),
        .glitch     (rx_glitch),
        .byte_valid (rx_byte_valid),
        .rx_byte    (rx_byte),
        .err        (rx_err)
    );

    // Transaction FSM with registered outputs and inline TX shifter
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            tx_frame    <= '0;
            code_shadow <= '0;
            data_shadow <= '0;
            rsp_q       <= '0;
            tx          <= UART_IDLE_LEVEL;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            timeout     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            timeout   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= UART_IDLE_LEVEL;
                    busy <= 1'b0;
                    if (req_valid && req_ready) begin
                        tx_frame  <= tx_load;
                        tx        <= 1'b0;
                        clk_cnt   <= '0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= SEND;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SEND: begin
                    if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BIT_W'(FRAME_LEN - 1)) begin
                            tx      <= UART_IDLE_LEVEL;
                            tmo_cnt <= '0;
                            state   <= WAIT_B0;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            tx       <= tx_frame[0];
                            tx_frame <= {UART_IDLE_LEVEL, tx_frame[TXS_W-1:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                WAIT_B0, WAIT_B1: begin
                    // A start edge in the expiry cycle still counts as in time
                    if (rx_fall_c) begin
                        state <= (state == WAIT_B0) ? RECV_B0 : RECV_B1;
                    end else if (tmo_cnt == TMO_W'(TMO_CYCLES - 1)) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RECV_B0: begin
                    if (rx_glitch) begin
                        state <= WAIT_B0;
                    end else if (rx_err) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (rx_byte_valid) begin
                        code_shadow <= rx_byte;
                        tmo_cnt     <= '0;
                        state       <= WAIT_B1;
                    end
                end
                RECV_B1: begin
                    if (rx_glitch) begin
                        state <= WAIT_B1;
                    end else if (rx_err) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (rx_byte_valid) begin
                        data_shadow <= rx_byte;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    rsp_q     <= '{code: code_shadow, data: data_shadow};
                    rsp_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_requester.sv
// Directed bench for uart_requester at 8 clocks per bit, 40-bit reply timeout.
// Build option: UART_REQ_PARITY_EN selects the 8E1 expectations and parity case.
module tb_uart_requester;

    localparam int unsigned CPB   = 8;
    localparam int unsigned TBITS = 40;
`ifdef UART_REQ_PARITY_EN
    localparam int unsigned FRAME = 11;
`else
    localparam int unsigned FRAME = 10;
`endif
    localparam int unsigned FRAME_CYC = FRAME * CPB;

    logic       clk_50mhz = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_cmd;
    logic       rx;
    logic       tx;
    logic       rsp_valid;
    logic [7:0] rsp_code;
    logic [7:0] rsp_data;
    logic       timeout;
    logic       frame_err;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    // Pulse monitor state
    int         cyc     = 0;
    int         n_rsp   = 0;
    int         n_tmo   = 0;
    int         n_ferr  = 0;
    int         n_multi = 0;
    int         tmo_cyc = 0;
    logic [7:0] cap_code  = 8'h00;
    logic [7:0] cap_data  = 8'h00;
    logic       cap_ready = 1'b0;
    logic       pend      = 1'b0;

    uart_requester #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TBITS)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .rx        (rx),
        .tx        (tx),
        .rsp_valid (rsp_valid),
        .rsp_code  (rsp_code),
        .rsp_data  (rsp_data),
        .timeout   (timeout),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    always @(posedge clk_50mhz) cyc <= cyc + 1;

    // Count result pulses and capture what was presented with them
    always @(negedge clk_50mhz) begin
        if (rsp_valid === 1'b1) begin
            n_rsp    <= n_rsp + 1;
            cap_code <= rsp_code;
            cap_data <= rsp_data;
        end
        if (timeout === 1'b1) begin
            n_tmo   <= n_tmo + 1;
            tmo_cyc <= cyc;
        end
        if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
        if ((32'(rsp_valid) + 32'(timeout) + 32'(frame_err)) > 32'd1) n_multi <= n_multi + 1;
        pend <= rsp_valid | timeout | frame_err;
        if (pend) cap_ready <= req_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_50mhz);
    endtask

    // Offer a command for one edge; h is the cycle count including the handshake edge
    task automatic handshake(input logic [7:0] cmd, output int h);
        req_valid = 1'b1;
        req_cmd   = cmd;
        tick();
        req_valid = 1'b0;
        h = cyc;
    endtask

    // Drive one reply frame on rx, each bit CPB cycles
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        logic [10:0] bits;
`ifdef UART_REQ_PARITY_EN
        bits = {stop_bit, par_bit, d, 1'b0};
`else
        bits = {par_bit, stop_bit, d, 1'b0};
`endif
        for (int i = 0; i < int'(FRAME); i++) begin
            rx = bits[i];
            repeat (CPB) tick();
        end
        rx = 1'b1;
    endtask

    // Bounded wait for the requester to be ready again
    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (!(req_ready === 1'b1 && busy === 1'b0) && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_ready"}, 32'(req_ready === 1'b1 && busy === 1'b0), 32'd1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got running want finished");
        $fatal(1);
    end

    initial begin
        int h;
        int s_rsp, s_tmo, s_ferr;
        logic [10:0] exp_frame;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 8'h00;
        rx        = 1'b1;
        repeat (3) tick();

        // Reset values
        chk("rst_tx",        32'(tx),        32'd1);
        chk("rst_ready",     32'(req_ready), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_timeout",   32'(timeout),   32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_code",      32'(rsp_code),  32'd0);
        chk("rst_data",      32'(rsp_data),  32'd0);

        reset = 1'b1;
        tick();
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Command 0xA5: start, 1,0,1,0,0,1,0,1, [parity 0], stop
`ifdef UART_REQ_PARITY_EN
        exp_frame = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        exp_frame = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
        s_rsp = n_rsp; s_tmo = n_tmo; s_ferr = n_ferr;
        handshake(8'hA5, h);
        for (int c = 0; c < int'(FRAME_CYC); c++) begin
            chk("tx_a5",      32'(tx),        32'(exp_frame[c / int'(CPB)]));
            chk("busy_send",  32'(busy),      32'd1);
            chk("ready_send", 32'(req_ready), 32'd0);
            tick();
        end
        repeat (63) tick();
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h37, 1'b1, 1'b1);
        wait_idle("rsp1", 400);
        chk("rsp1_count",    32'(n_rsp - s_rsp),   32'd1);
        chk("rsp1_code",     32'(cap_code),        32'h01);
        chk("rsp1_data",     32'(cap_data),        32'h37);
        chk("rsp1_ready",    32'(cap_ready),       32'd1);
        chk("rsp1_no_tmo",   32'(n_tmo - s_tmo),   32'd0);
        chk("rsp1_no_ferr",  32'(n_ferr - s_ferr), 32'd0);
        chk("rsp1_hold_c",   32'(rsp_code),        32'h01);
        chk("rsp1_hold_d",   32'(rsp_data),        32'h37);

        // No reply: timeout 320 cycles after the stop bit ends
        s_rsp = n_rsp; s_tmo = n_tmo; s_ferr = n_ferr;
        handshake(8'h5A, h);
        wait_idle("tmo", 1000);
        chk("tmo_count",   32'(n_tmo - s_tmo),   32'd1);
        chk("tmo_time",    32'(tmo_cyc - h),     32'(FRAME_CYC + 320));
        chk("tmo_no_rsp",  32'(n_rsp - s_rsp),   32'd0);
        chk("tmo_no_ferr", 32'(n_ferr - s_ferr), 32'd0);
        chk("tmo_ready",   32'(cap_ready),       32'd1);
        chk("tmo_code",    32'(rsp_code),        32'h01);
        chk("tmo_data",    32'(rsp_data),        32'h37);

        // Second reply byte with a bad stop bit
        s_rsp = n_rsp; s_tmo = n_tmo; s_ferr = n_ferr;
        handshake(8'h33, h);
        repeat (FRAME_CYC) tick();
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b0);
        wait_idle("ferr", 400);
        chk("ferr_count",  32'(n_ferr - s_ferr), 32'd1);
        chk("ferr_no_rsp", 32'(n_rsp - s_rsp),   32'd0);
        chk("ferr_no_tmo", 32'(n_tmo - s_tmo),   32'd0);
        chk("ferr_busy",   32'(busy),            32'd0);
        chk("ferr_code",   32'(rsp_code),        32'h01);

        // Two-cycle low glitch while waiting, then a good reply
        s_rsp = n_rsp; s_tmo = n_tmo; s_ferr = n_ferr;
        handshake(8'h81, h);
        repeat (FRAME_CYC + 10) tick();
        rx = 1'b0;
        repeat (2) tick();
        rx = 1'b1;
        repeat (20) tick();
        send_frame(8'h02, 1'b1, 1'b1);
        send_frame(8'h9C, 1'b1, 1'b0);
        wait_idle("glitch", 400);
        chk("glitch_count",   32'(n_rsp - s_rsp),   32'd1);
        chk("glitch_code",    32'(cap_code),        32'h02);
        chk("glitch_data",    32'(cap_data),        32'h9C);
        chk("glitch_no_tmo",  32'(n_tmo - s_tmo),   32'd0);
        chk("glitch_no_ferr", 32'(n_ferr - s_ferr), 32'd0);

`ifdef UART_REQ_PARITY_EN
        // Command 0x07 carries parity 1; reply 0x03 with parity 1 is wrong
        exp_frame = {1'b1, 1'b1, 8'h07, 1'b0};
        s_rsp = n_rsp; s_tmo = n_tmo; s_ferr = n_ferr;
        handshake(8'h07, h);
        for (int c = 0; c < int'(FRAME_CYC); c++) begin
            chk("tx_07", 32'(tx), 32'(exp_frame[c / int'(CPB)]));
            tick();
        end
        send_frame(8'h03, 1'b1, 1'b1);
        wait_idle("par", 400);
        chk("par_ferr",   32'(n_ferr - s_ferr), 32'd1);
        chk("par_no_rsp", 32'(n_rsp - s_rsp),   32'd0);
        chk("par_no_tmo", 32'(n_tmo - s_tmo),   32'd0);
`endif

        // Reset asserted during data bit 3 (frame bit 4) of the command
        s_rsp = n_rsp; s_tmo = n_tmo; s_ferr = n_ferr;
        handshake(8'hA5, h);
        repeat (35) tick();
        chk("midrst_tx_before", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_tx",    32'(tx),        32'd1);
        chk("midrst_busy",  32'(busy),      32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_code",  32'(rsp_code),  32'd0);
        chk("midrst_data",  32'(rsp_data),  32'd0);
        repeat (3) tick();
        reset = 1'b1;
        wait_idle("midrst", 20);
        chk("midrst_pulses", 32'((n_rsp - s_rsp) + (n_tmo - s_tmo) + (n_ferr - s_ferr)), 32'd0);

        chk("pulse_excl", 32'(n_multi), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_requester.md
Name: uart_requester

Overview:
- Host-side initiator for the sensor UART command/response link: the end that issues the requests the FPGA command decoder answers.
- Takes a one-byte command from local logic and serialises it 8N1 on tx.
- Then receives the two-byte reply (code byte, then data byte) on rx, with a reply timeout.
- Used as a loopback/board-to-board test master and as the requester on a second FPGA.

Parameters:
- CLKS_PER_BIT, 434, clk_50mhz cycles per UART bit (115200 baud at 50 MHz); minimum 4.
- TIMEOUT_BITS, 40, bit times allowed from end of tx stop bit to start of each reply byte.

Ports:
- clk_50mhz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  command offered
- req_ready  out  1  high in IDLE only; handshake on req_valid && req_ready
- req_cmd  in  8  command byte, captured on handshake
- rx  in  1  serial input from responder, idle high
- tx  out  1  serial output to responder, idle high
- rsp_valid  out  1  one-cycle pulse, reply complete
- rsp_code  out  8  first reply byte, held until next rsp_valid
- rsp_data  out  8  second reply byte, held until next rsp_valid
- timeout  out  1  one-cycle pulse, reply byte not started in time
- frame_err  out  1  one-cycle pulse, bad stop bit (or parity, see option)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0) values: tx=1, req_ready=0 while asserted, busy=0, rsp_valid=0, timeout=0, frame_err=0, rsp_code=0, rsp_data=0, state=IDLE, all counters 0.
- Reset is honoured mid-frame: tx returns to 1 immediately and the transaction is lost; no pulses are emitted.
- rx passes through a 2-flop synchroniser before any use; the synchroniser flops reset to 1.
- FSM states: IDLE, SEND, WAIT_B0, RECV_B0, WAIT_B1, RECV_B1, DONE.
- IDLE:
  - On handshake, latch req_cmd and go to SEND on the next edge.
  - rx activity in IDLE is ignored (unsolicited bytes dropped).
- SEND:
  - Start bit, then 8 data bits LSB first, then stop bit; each bit held exactly CLKS_PER_BIT cycles.
  - First tx=0 cycle is 1 cycle after the handshake.
  - After the last stop-bit cycle, go to WAIT_B0 and clear the timeout counter.
- WAIT_B0 / WAIT_B1:
  - Timeout counter increments each clock.
  - A synchronised falling edge on rx moves to RECV_Bn.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT cycles: pulse timeout, go to IDLE, rsp_* unchanged.
  - If the edge and the expiry fall in the same cycle, the edge wins.
- RECV_Bn:
  - Start bit re-checked at CLKS_PER_BIT/2 (integer divide); if rx=1 there, it was a glitch: return to WAIT_Bn, timeout counter not cleared.
  - Each data bit sampled CLKS_PER_BIT after the previous sample; stop bit sampled likewise.
  - Stop=0: pulse frame_err, go to IDLE, byte discarded.
  - Stop=1: B0 goes to a shadow register, state to WAIT_B1 with the timeout counter cleared; B1 goes to DONE.
- DONE: rsp_code and rsp_data load together, rsp_valid pulses for one cycle, return to IDLE.
- req_ready becomes 1 on the cycle after DONE, timeout, or frame_err.
- Pulses are mutually exclusive; at most one per transaction.
- All counters are sized with $clog2 of their maximum and must not wrap before their terminal count.

Optional Feature:
- Macro UART_REQ_PARITY_EN.
- Defined:
  - Frames are 8E1: an even-parity bit (XOR of the data bits) sits between data and stop, both directions.
  - A received parity mismatch pulses frame_err and aborts, the same as a bad stop bit.
  - The parity bit is checked before the stop bit; a single frame_err is raised even if both are bad.
- Undefined: 8N1, no parity logic present.

Decomposition:
- Package uart_pkg holds:
  - state enum
  - DEFAULT_CLKS_PER_BIT=434
  - frame length constants (10, or 11 with parity)
  - UART_IDLE_LEVEL=1'b1
- One sub-module, uart_rx_core:
  - Synchroniser, mid-bit sampler, stop/parity check.
  - Outputs byte_valid, byte, err.
  - An enable input arms it in WAIT_Bn.
- TX shift logic stays inline in uart_requester.

Test Plan:
- CLKS_PER_BIT=8; req_cmd=0xA5 handshake → tx=0 for cycles 1-8, then bits 1,0,1,0,0,1,0,1, then tx=1; busy=1 throughout; req_ready=0.
- Responder model replies 0x01 then 0x37, 8 bit-times after the stop bit → one rsp_valid pulse with rsp_code=0x01, rsp_data=0x37; req_ready back to 1 the next cycle.
- No reply, TIMEOUT_BITS=40, CLKS_PER_BIT=8 → timeout pulse exactly 320 cycles after the stop bit ends; rsp_* retain their previous values.
- Reply 0x01, then second byte with stop=0 → frame_err pulse, no rsp_valid, state IDLE.
- 2-cycle low glitch on rx in WAIT_B0, then a valid reply → glitch ignored, correct rsp; separately, reset=0 mid-SEND at bit 4 → tx=1 the same cycle, all outputs at reset values.
- With UART_REQ_PARITY_EN: cmd 0x07 → parity bit 1 sent; reply byte 0x03 with parity 1 → frame_err pulse.
